// File: rtl/fc_failover_pkg.sv
// Shared definitions for the fast-command source failover selector:
// FSM state encodings, channel-index width helper and a priority encoder.
package fc_failover_pkg;

   localparam logic [1:0] ST_NONE   = 2'd0;
   localparam logic [1:0] ST_GUARD  = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } prienc_t;

   function automatic int chWidth(input int nCh);
      return (nCh <= 2) ? 1 : $clog2(nCh);
   endfunction

   // Lowest set bit wins, so channel 0 has the highest priority.
   function automatic prienc_t lowestSet(input logic [15:0] vec);
      prienc_t res;
      res.found = 1'b0;
      res.idx   = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (vec[i]) begin
            res.found = 1'b1;
            res.idx   = 4'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fc_src_qualifier.sv
// One channel's hold-off timer: a source is qualified only after it has been
// alive and enabled for HOLDOFF_CYCLES consecutive cycles.
module fc_src_qualifier
   import fc_failover_pkg::*;
#(
   parameter int HOLDOFF_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset_in,
   input  logic i_alive,
   input  logic i_enable,
   output logic o_qualified
);

   localparam int CNT_W = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLDOFF_CYCLES);

   logic [CNT_W-1:0] r_count;
   logic             r_qual;
   logic             w_on;

   assign w_on        = i_alive && i_enable;
   assign o_qualified = r_qual;

   // Qualification drops on the same edge the counter clears, so loss is never delayed.
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         r_count <= '0;
         r_qual  <= 1'b0;
      end else if (!w_on) begin
         r_count <= '0;
         r_qual  <= 1'b0;
      end else begin
         if (r_count != HOLD_MAX) begin
            r_count <= r_count + CNT_W'(1);
         end
         r_qual <= (r_count == HOLD_MAX);
      end
   end

endmodule

// File: rtl/fc_source_failover.sv
// N-channel fast-command source selector with hold-off qualification, priority,
// manual override, optional revertive failover and an idle guard on every switch.
// Optional statistics (switch_count, last_lost_ch, stats_clear): FC_FAILOVER_STATS_EN.
module fc_source_failover
   import fc_failover_pkg::*;
#(
   parameter int   N_CH           = 4,
   parameter int   HOLDOFF_CYCLES = 1024,
   parameter int   GUARD_CYCLES   = 64,
   parameter logic IDLE_LEVEL     = 1'b0,
   parameter int   REVERTIVE      = 1,
   localparam int  CH_W           = chWidth(N_CH)
) (
   input  logic            clk,
   input  logic            reset_in,
   input  logic [N_CH-1:0] fc_rise,
   input  logic [N_CH-1:0] fc_fall,
   input  logic [N_CH-1:0] src_alive,
   input  logic [N_CH-1:0] cfg_edgesel,
   input  logic [N_CH-1:0] cfg_invert,
   input  logic [N_CH-1:0] cfg_enable,
   input  logic            cfg_manual_en,
   input  logic [CH_W-1:0] cfg_manual_ch,
   output logic            FC_out,
   output logic [CH_W-1:0] active_ch,
   output logic            active_valid,
   output logic            switching,
   output logic [N_CH-1:0] qualified
`ifdef FC_FAILOVER_STATS_EN
   ,
   input  logic            stats_clear,
   output logic [15:0]     switch_count,
   output logic [CH_W-1:0] last_lost_ch
`endif
);

   localparam int GCNT_W = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES);
   localparam logic [GCNT_W-1:0] GUARD_LAST = (GUARD_CYCLES == 0) ? '0 : GCNT_W'(GUARD_CYCLES - 1);

   logic [1:0]        r_state;
   logic [CH_W-1:0]   r_activeCh;
   logic [GCNT_W-1:0] r_guardCnt;
   logic              r_fc;

   logic [N_CH-1:0]   w_data;
   logic [N_CH-1:0]   w_qual;
   logic [15:0]       w_dataExt;
   logic [15:0]       w_qualExt;
   prienc_t           w_pe;
   logic              w_targetValid;
   logic [CH_W-1:0]   w_target;
   logic              w_targetDiff;
   logic              w_lost;
   logic              w_leaveActive;
   logic [1:0]        w_stateNext;
   logic [CH_W-1:0]   w_chNext;
   logic [GCNT_W-1:0] w_cntNext;
   logic              w_fcNext;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign w_data[g] = (cfg_edgesel[g] ? fc_fall[g] : fc_rise[g]) ^ cfg_invert[g];

      fc_src_qualifier #(
         .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
      ) u_qual (
         .clk        (clk),
         .reset_in   (reset_in),
         .i_alive    (src_alive[g]),
         .i_enable   (cfg_enable[g]),
         .o_qualified(w_qual[g])
      );
   end

   assign w_dataExt = 16'(w_data);
   assign w_qualExt = 16'(w_qual);
   assign w_pe      = lowestSet(w_qualExt);

   assign w_targetValid = cfg_manual_en ? ((int'(cfg_manual_ch) < N_CH) && w_qualExt[cfg_manual_ch])
                                        : w_pe.found;
   assign w_target      = cfg_manual_en ? cfg_manual_ch : CH_W'(w_pe.idx);
   assign w_targetDiff  = w_targetValid && (w_target != r_activeCh);
   assign w_lost        = !w_qualExt[r_activeCh];

   // In manual mode the forced channel always rules; in auto mode a healthy
   // channel is only pre-empted by a better one when failover is revertive.
   assign w_leaveActive = cfg_manual_en ? (!w_targetValid || w_targetDiff)
                                        : (w_lost || ((REVERTIVE != 0) && w_targetDiff));

   always_comb begin
      w_stateNext = r_state;
      w_chNext    = r_activeCh;
      w_cntNext   = r_guardCnt;
      w_fcNext    = IDLE_LEVEL;
      case (r_state)
         ST_NONE: begin
            if (w_targetValid) begin
               w_stateNext = ST_GUARD;
               w_chNext    = w_target;
               w_cntNext   = '0;
            end
         end
         ST_GUARD: begin
            if (w_targetDiff) begin
               w_chNext  = w_target;
               w_cntNext = '0;
            end else if (r_guardCnt == GUARD_LAST) begin
               w_stateNext = w_lost ? ST_NONE : ST_ACTIVE;
            end else begin
               w_cntNext = r_guardCnt + GCNT_W'(1);
            end
         end
         ST_ACTIVE: begin
            if (w_leaveActive) begin
               if (w_targetValid) begin
                  w_stateNext = ST_GUARD;
                  w_chNext    = w_target;
                  w_cntNext   = '0;
               end else begin
                  w_stateNext = ST_NONE;
               end
            end else begin
               w_fcNext = w_dataExt[r_activeCh];
            end
         end
         default: begin
            w_stateNext = ST_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         r_state    <= ST_NONE;
         r_activeCh <= '0;
         r_guardCnt <= '0;
         r_fc       <= IDLE_LEVEL;
      end else begin
         r_state    <= w_stateNext;
         r_activeCh <= w_chNext;
         r_guardCnt <= w_cntNext;
         r_fc       <= w_fcNext;
      end
   end

   assign FC_out       = r_fc;
   assign active_ch    = r_activeCh;
   assign active_valid = (r_state == ST_ACTIVE);
   assign switching    = (r_state == ST_GUARD);
   assign qualified    = w_qual;

`ifdef FC_FAILOVER_STATS_EN
   logic [15:0]     r_switchCount;
   logic [CH_W-1:0] r_lastLostCh;

   // Clear takes precedence over a same-cycle event.
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         r_switchCount <= '0;
         r_lastLostCh  <= '0;
      end else if (stats_clear) begin
         r_switchCount <= '0;
         r_lastLostCh  <= '0;
      end else if (r_state == ST_ACTIVE) begin
         if (w_leaveActive && (r_switchCount != 16'hFFFF)) begin
            r_switchCount <= r_switchCount + 16'd1;
         end
         if (w_lost) begin
            r_lastLostCh <= r_activeCh;
         end
      end
   end

   assign switch_count = r_switchCount;
   assign last_lost_ch = r_lastLostCh;
`endif

endmodule

// File: doc/fc_source_failover.md
Name: fc_source_failover

Overview:
- N-channel successor to the single ext/int fast-command selector.
- Takes N fast-command bit streams, already DDR-sampled into the 320 MHz FC clock domain (rise and fall samples per channel), plus a per-channel "source alive" flag from clock monitors.
- Per channel: applies edge select and inversion, qualifies each source with a hold-off timer, and picks one with priority, manual override and optional revertive failover.
- Inserts a guard interval of idle level on every switch, so downstream decoders see a clean break rather than a spliced stream.

Parameters:
- N_CH, 4, number of fast-command source channels (2..16)
- HOLDOFF_CYCLES, 1024, consecutive alive cycles before a channel is qualified
- GUARD_CYCLES, 64, idle-level cycles inserted between deselect and select
- IDLE_LEVEL, 1'b0, FC_out value while no source is driven
- REVERTIVE, 1, 1 = return to a higher-priority channel once it is qualified again

Ports:
- clk, in, 1, 320 MHz fast-command clock
- reset_in, in, 1, asynchronous active-high reset
- fc_rise, in, N_CH, per-channel rising-edge sample
- fc_fall, in, N_CH, per-channel falling-edge sample
- src_alive, in, N_CH, per-channel clock-present flag (already synchronised)
- cfg_edgesel, in, N_CH, 1 = use fall sample
- cfg_invert, in, N_CH, 1 = invert channel data
- cfg_enable, in, N_CH, channel allowed for selection
- cfg_manual_en, in, 1, force cfg_manual_ch
- cfg_manual_ch, in, CH_W, forced channel; CH_W = max(1, $clog2(N_CH))
- FC_out, out, 1, selected fast-command stream
- active_ch, out, CH_W, currently driven channel
- active_valid, out, 1, a channel is being driven
- switching, out, 1, guard interval in progress
- qualified, out, N_CH, per-channel qualified status

Behaviour:
- Reset: FC_out=IDLE_LEVEL, active_ch=0, active_valid=0, switching=0, qualified=0, all hold-off counters=0, state=NONE.
- Per-channel data: d[i] = (cfg_edgesel[i] ? fc_fall[i] : fc_rise[i]) ^ cfg_invert[i]. Combinational.
- Hold-off counters:
  - Counter i increments while src_alive[i] && cfg_enable[i]; it saturates at HOLDOFF_CYCLES.
  - It clears in the same cycle either input is low.
  - qualified[i] = (count == HOLDOFF_CYCLES), registered.
- Target channel:
  - Manual mode: cfg_manual_ch if it is qualified and < N_CH; otherwise no target.
  - Auto mode: the lowest-index qualified channel; none if none is qualified.
- NONE state: FC_out=IDLE_LEVEL, active_valid=0. A target exists -> latch the target into active_ch, go to GUARD.
- GUARD state: switching=1, FC_out=IDLE_LEVEL, guard counter runs GUARD_CYCLES cycles.
  - At terminal count: if active_ch is still qualified -> ACTIVE; otherwise -> NONE.
- ACTIVE state: FC_out <= d[active_ch], registered, 1-cycle latency. active_valid=1.
  - If active_ch loses qualification: FC_out takes IDLE_LEVEL on the next cycle. Go to NONE.
  - If the target differs from active_ch: latch the new target, go to GUARD.
  - Auto mode with REVERTIVE=0: a higher-priority channel does not pre-empt a qualified active channel. Only loss or a manual change triggers a switch.
- Simultaneous events: loss of the active channel and a new target appearing in the same cycle -> go straight to GUARD with the new target (skip NONE).
- Config changes mid-GUARD: if the target changes during GUARD, restart GUARD with the new channel.
- GUARD_CYCLES=0: GUARD lasts exactly 1 cycle.
- reset_in asserted mid-operation: every output returns to its reset value immediately (asynchronous).

Optional Feature:
- Macro: FC_FAILOVER_STATS_EN.
- Defined: adds output switch_count[15:0] and output last_lost_ch[CH_W-1:0].
  - switch_count increments on each ACTIVE->GUARD or ACTIVE->NONE transition and saturates at 16'hFFFF.
  - last_lost_ch captures active_ch whenever the active channel loses qualification.
  - Both reset to 0.
  - Input stats_clear (1 bit) zeroes both registers synchronously; clear wins over a same-cycle increment.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package fc_failover_pkg holds:
  - the state enum {NONE, GUARD, ACTIVE}
  - a function for the CH_W calculation
  - a priority-encoder function (lowest set bit plus found flag)
- One sub-module: fc_src_qualifier. It holds a single channel's hold-off counter and qualified flag, and is instantiated N_CH times in a generate loop.

Test Plan:
- Reset, then all 4 channels alive and enabled:
  - qualified=4'b1111 at cycle 1025 after reset release
  - active_ch=0 after a further 64 guard cycles
  - FC_out equals ch0 rise data, 1-cycle delayed
- Drop src_alive[0] while ch0 is active:
  - FC_out=IDLE_LEVEL the next cycle
  - switching=1 for 64 cycles, then active_ch=1
- REVERTIVE=1 with ch0 restored: ch0 re-qualifies after 1024 cycles, then GUARD, then active_ch=0.
- REVERTIVE=0 with ch0 restored: ch0 re-qualifies but active_ch stays 1.
- Manual mode, cfg_manual_ch=3:
  - ch3 has cfg_invert=1 and cfg_edgesel=1
  - FC_out = ~fc_fall[3]
  - cfg_manual_ch=3 while ch3 is unqualified -> NONE, FC_out=IDLE_LEVEL
- Same-cycle events:
  - active-channel loss together with a manual change in the same cycle -> direct GUARD to the new channel, no NONE cycle
  - reset_in pulsed mid-GUARD -> all outputs at their reset values immediately
- Stats build (FC_FAILOVER_STATS_EN):
  - three failovers -> switch_count=3, last_lost_ch equals the most recently dropped channel
  - stats_clear -> both 0
